addsub_serial_alu: RTL and testbench
====================================

// Module: addsub_serial_alu
// PURPOSE
//  Parametrised successor to the 4-bit carry-lookahead add/sub core: DIGITS-nibble operands A/B
//  entered hex-digit-by-digit from the keypad, then add/sub computed one nibble per cycle.
//  Uses a 4-bit CLA slice, carry held in a register; ZNVC flags; busy/done handshake.
//  Sits between keypad_input (nibble + trig) and the hex2sevenMX display / LEDR flag lamps.
// PARAMETERS
//  DIGITS  4  operand width in hex digits (W = 4*DIGITS bits); legal range 1..8
// PORTS
//  clk        in   1    system clock; all state changes on posedge
//  reset      in   1    asynchronous, active-high; clears all state
//  key_nibble in   4    hex digit from keypad decoder
//  key_valid  in   1    one-cycle strobe (keypad trig): key_nibble is valid
//  load_sel   in   1    target of digit entry / clear: 0 = A, 1 = B
//  clear_sel  in   1    one-cycle strobe: zero the operand chosen by load_sel
//  op_sub     in   1    0 = A+B, 1 = A-B; sampled on the submit cycle
//  submit     in   1    one-cycle strobe: start an operation
//  busy       out  1    high while computing
//  done       out  1    one-cycle pulse when result/flags update
//  a_out      out  W    operand A register
//  b_out      out  W    operand B register
//  result     out  W    last completed result
//  flags      out  4    {Z,N,V,C} of last completed result
// BEHAVIOUR
//  Reset: a_out/b_out/result = 0, flags = 0, busy = 0, done = 0, state = IDLE.
//  FSM: IDLE -> CALC on submit; CALC -> DONE after nibble DIGITS-1; DONE -> IDLE next cycle
//   (or straight to CALC if submit is asserted in DONE).
//  Entry (IDLE/DONE only): key_valid -> sel_reg <= {sel_reg[W-5:0], key_nibble}; MS digit drops off.
//   clear_sel -> sel_reg <= 0; clear_sel wins over key_valid in the same cycle.
//  Start: submit in IDLE/DONE snapshots A, B, op_sub; idx <= 0; carry <= op_sub; busy <= 1
//   on the next edge. submit wins over key_valid/clear_sel in the same cycle (entry dropped).
//  CALC, per cycle: {c,s} = A[4i+:4] + (B[4i+:4] ^ {4{sub}}) + carry; acc[4i+:4] <= s;
//   carry <= c; idx++. Slice carry into bit 3 is kept for V.
//  Latency: busy high exactly DIGITS cycles; done pulses on the following cycle, when result <= acc
//   and flags update at the same edge; busy low in DONE.
//  Flags: Z = (acc == 0); N = acc[W-1]; C = raw carry out of MS nibble (sub: 1 = no borrow);
//   V = carry into bit W-1 XOR carry out of bit W-1.
//  Arithmetic modulo 2^W; no saturation.
//  During CALC: key_valid, clear_sel, submit ignored; a_out/b_out/result/flags hold.
//  Reset mid-CALC aborts: everything to reset values; no done pulse.
// STRUCTURE
//  Package addsub_pkg: state_t enum {IDLE, CALC, DONE}; flag index localparams
//   FLAG_Z=3, FLAG_N=2, FLAG_V=1, FLAG_C=0; OP_ADD=1'b0, OP_SUB=1'b1.
//  Sub-module cla4_slice (combinational 4-bit CLA):
//   inputs a, b, cin; outputs sum, cout, c3 (carry into bit 3).
//  Top holds FSM, operand/accumulator registers and the idx counter ($clog2(DIGITS), min 1 bit).
// TESTING (DIGITS=4 unless noted)
//  1 A=0 | keys 1,2,3,4 load_sel=0 -> a_out=16'h1234; then key 5 -> 16'h2345;
//    clear_sel -> a_out=0, b_out untouched.
//  2 A=7FFF B=0001 add -> busy 4 cycles, then done pulse; result=8000,
//    flags Z0 N1 V1 C0.
//  3 A=0005 B=0005 sub -> result=0000, Z1 N0 V0 C1; A=0003 B=0005 sub -> FFFE, Z0 N1 V0 C0.
//  4 submit + key_valid same cycle -> operand unchanged, op starts;
//    key/submit during busy -> ignored, result unchanged.
//  5 reset asserted at 2nd CALC cycle -> all outputs 0 immediately, no done;
//    new op after release correct.
//  6 DIGITS=1: A=7 B=1 add -> result=8, N1 V1; busy 1 cycle; submit in DONE -> back-to-back op.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/sub ALU: FSM state encoding,
// bit positions inside the {Z,N,V,C} flag vector and op_sub encodings.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  4  addends (b already inverted by the caller for subtraction)
//   cin   in  1  carry in
//   sum   out 4  a + b + cin, low 4 bits
//   cout  out 1  carry out of bit 3
//   c3    out 1  carry into bit 3 (used for signed overflow detection)
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
    c3   = c[3];
  end

endmodule

// File: rtl/addsub_serial_alu.sv
// Digit-serial add/sub ALU. Operands A and B (DIGITS hex digits each) are
// shifted in from the keypad one nibble at a time; submit then computes A+B
// or A-B one nibble per cycle through a single 4-bit CLA slice, with the
// inter-nibble carry held in a register.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   key_nibble   hex digit from the keypad, qualified by key_valid
//   load_sel     entry/clear target: 0 = A, 1 = B
//   clear_sel    zero the selected operand
//   op_sub       0 = add, 1 = subtract; captured with submit
//   submit       start an operation (only honoured in IDLE/DONE)
//   busy         high during the DIGITS computation cycles
//   done         one-cycle pulse when result/flags have just updated
//   a_out, b_out operand registers
//   result       last completed result
//   flags        {Z,N,V,C} of the last completed result
module addsub_serial_alu
  import addsub_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            key_nibble,
  input  logic                  key_valid,
  input  logic                  load_sel,
  input  logic                  clear_sel,
  input  logic                  op_sub,
  input  logic                  submit,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   a_out,
  output logic [4*DIGITS-1:0]   b_out,
  output logic [4*DIGITS-1:0]   result,
  output logic [3:0]            flags
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic [3:0]      flags_q, flags_d;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      slice_sum;
  logic            slice_cout;
  logic            slice_c3;
  logic [W-1:0]    acc_upd;
  logic            last_digit;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the
  // initial carry (carry_q is seeded with op_sub on submit).
  cla4_slice u_slice (
    .a    (nib_a),
    .b    (nib_b ^ {4{sub_q}}),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_comb begin
    nib_a   = '0;
    nib_b   = '0;
    acc_upd = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a            = a_q[4*i +: 4];
        nib_b            = b_q[4*i +: 4];
        acc_upd[4*i +: 4] = slice_sum;
      end
    end
    last_digit = (idx_q == IW'(DIGITS - 1));
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (submit) begin
          // submit takes priority; any same-cycle key/clear is dropped
          state_d = CALC;
          sub_d   = op_sub;
          carry_d = op_sub;
          idx_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
          if (clear_sel) begin
            if (load_sel) b_d = '0;
            else          a_d = '0;
          end else if (key_valid) begin
            if (load_sel) b_d = (b_q << 4) | W'(key_nibble);
            else          a_d = (a_q << 4) | W'(key_nibble);
          end
        end
      end
      CALC: begin
        acc_d   = acc_upd;
        carry_d = slice_cout;
        idx_d   = idx_q + IW'(1);
        if (last_digit) begin
          state_d         = DONE;
          result_d        = acc_upd;
          flags_d[FLAG_Z] = (acc_upd == '0);
          flags_d[FLAG_N] = acc_upd[W-1];
          flags_d[FLAG_V] = slice_c3 ^ slice_cout;
          flags_d[FLAG_C] = slice_cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign a_out  = a_q;
  assign b_out  = b_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_addsub_serial_alu.sv
module tb_addsub_serial_alu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DIGITS = 4 instance
  logic [3:0]  key_nibble;
  logic        key_valid, load_sel, clear_sel, op_sub, submit;
  logic        busy, done;
  logic [15:0] a_out, b_out, result;
  logic [3:0]  flags;

  // DIGITS = 1 instance
  logic [3:0]  key_nibble1;
  logic        key_valid1, load_sel1, clear_sel1, op_sub1, submit1;
  logic        busy1, done1;
  logic [3:0]  a_out1, b_out1, result1;
  logic [3:0]  flags1;

  int n_pass = 0;
  int n_total = 0;

  addsub_serial_alu #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .key_nibble(key_nibble), .key_valid(key_valid),
    .load_sel(load_sel), .clear_sel(clear_sel), .op_sub(op_sub), .submit(submit),
    .busy(busy), .done(done), .a_out(a_out), .b_out(b_out), .result(result),
    .flags(flags)
  );

  addsub_serial_alu #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .key_nibble(key_nibble1), .key_valid(key_valid1),
    .load_sel(load_sel1), .clear_sel(clear_sel1), .op_sub(op_sub1), .submit(submit1),
    .busy(busy1), .done(done1), .a_out(a_out1), .b_out(b_out1), .result(result1),
    .flags(flags1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d, input logic sel);
    key_nibble = d; load_sel = sel; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic clr(input logic sel);
    load_sel = sel; clear_sel = 1'b1;
    step();
    clear_sel = 1'b0;
  endtask

  task automatic load16(input logic [15:0] v, input logic sel);
    clr(sel);
    key(v[15:12], sel);
    key(v[11:8], sel);
    key(v[7:4], sel);
    key(v[3:0], sel);
  endtask

  // Submit, expect busy for 4 cycles, then a one-cycle done with result/flags.
  task automatic run_op(input string tag, input logic sub,
                        input logic [15:0] exp_res, input logic [3:0] exp_flg);
    op_sub = sub; submit = 1'b1;
    step();
    submit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      step();
    end
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flg});
    step();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    key_nibble = '0; key_valid = 0; load_sel = 0; clear_sel = 0; op_sub = 0; submit = 0;
    key_nibble1 = '0; key_valid1 = 0; load_sel1 = 0; clear_sel1 = 0; op_sub1 = 0; submit1 = 0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_a", {16'd0, a_out}, 32'h0);
    chk("rst_b", {16'd0, b_out}, 32'h0);
    chk("rst_result", {16'd0, result}, 32'h0);
    chk("rst_flags", {28'd0, flags}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // 1: digit entry, shift-out of MS digit, clear of selected operand only
    key(4'h9, 1'b1);
    chk("entry_b9", {16'd0, b_out}, 32'h0009);
    key(4'h1, 1'b0); key(4'h2, 1'b0); key(4'h3, 1'b0); key(4'h4, 1'b0);
    chk("entry_a1234", {16'd0, a_out}, 32'h1234);
    key(4'h5, 1'b0);
    chk("entry_a2345", {16'd0, a_out}, 32'h2345);
    // clear wins over a same-cycle key
    key_nibble = 4'hE; key_valid = 1'b1; clear_sel = 1'b1; load_sel = 1'b0;
    step();
    key_valid = 1'b0; clear_sel = 1'b0;
    chk("clear_a", {16'd0, a_out}, 32'h0);
    chk("clear_b_untouched", {16'd0, b_out}, 32'h0009);

    // 2: signed overflow on add
    load16(16'h7FFF, 1'b0);
    load16(16'h0001, 1'b1);
    chk("load_a7fff", {16'd0, a_out}, 32'h7FFF);
    run_op("add_ovf", 1'b0, 16'h8000, 4'b0110);

    // 3: subtraction, zero result and borrow
    load16(16'h0005, 1'b0);
    load16(16'h0005, 1'b1);
    run_op("sub_zero", 1'b1, 16'h0000, 4'b1001);
    load16(16'h0003, 1'b0);
    run_op("sub_borrow", 1'b1, 16'hFFFE, 4'b0100);

    // 4: submit beats same-cycle key; inputs ignored while busy
    key_nibble = 4'hF; load_sel = 1'b0; key_valid = 1'b1; op_sub = 1'b0; submit = 1'b1;
    step();
    key_valid = 1'b0; submit = 1'b0;
    chk("sub_key_a_hold", {16'd0, a_out}, 32'h0003);
    chk("sub_key_busy", {31'd0, busy}, 32'd1);
    key_nibble = 4'h7; load_sel = 1'b1; key_valid = 1'b1; clear_sel = 1'b1;
    submit = 1'b1; op_sub = 1'b1;
    step();
    key_valid = 1'b0; clear_sel = 1'b0; submit = 1'b0;
    chk("busy_b_hold", {16'd0, b_out}, 32'h0005);
    chk("busy_a_hold", {16'd0, a_out}, 32'h0003);
    chk("busy_result_hold", {16'd0, result}, 32'hFFFE);
    chk("busy_flags_hold", {28'd0, flags}, 32'h4);
    step();
    step();
    chk("busy_4th", {31'd0, busy}, 32'd1);
    step();
    chk("ignored_done", {31'd0, done}, 32'd1);
    chk("ignored_result", {16'd0, result}, 32'h0008);
    chk("ignored_flags", {28'd0, flags}, 32'h0);
    step();

    // 5: reset during the 2nd CALC cycle aborts everything
    op_sub = 1'b0; submit = 1'b1;
    step();
    submit = 1'b0;
    step();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_a", {16'd0, a_out}, 32'h0);
    chk("abort_b", {16'd0, b_out}, 32'h0);
    chk("abort_result", {16'd0, result}, 32'h0);
    chk("abort_flags", {28'd0, flags}, 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      step();
    end
    key(4'h1, 1'b0);
    key(4'h2, 1'b1);
    run_op("after_abort", 1'b0, 16'h0003, 4'b0000);

    // 6: DIGITS = 1, single-cycle busy and back-to-back op from DONE
    key_nibble1 = 4'h7; load_sel1 = 1'b0; key_valid1 = 1'b1;
    step();
    key_nibble1 = 4'h1; load_sel1 = 1'b1;
    step();
    key_valid1 = 1'b0;
    chk("d1_a", {28'd0, a_out1}, 32'h7);
    chk("d1_b", {28'd0, b_out1}, 32'h1);
    op_sub1 = 1'b0; submit1 = 1'b1;
    step();
    submit1 = 1'b0;
    chk("d1_busy", {31'd0, busy1}, 32'd1);
    step();
    chk("d1_busy_low", {31'd0, busy1}, 32'd0);
    chk("d1_done", {31'd0, done1}, 32'd1);
    chk("d1_result", {28'd0, result1}, 32'h8);
    chk("d1_flags", {28'd0, flags1}, 32'h6);
    op_sub1 = 1'b1; submit1 = 1'b1;
    step();
    submit1 = 1'b0;
    chk("d1_b2b_busy", {31'd0, busy1}, 32'd1);
    chk("d1_b2b_nodone", {31'd0, done1}, 32'd0);
    step();
    chk("d1_b2b_done", {31'd0, done1}, 32'd1);
    chk("d1_b2b_result", {28'd0, result1}, 32'h6);
    chk("d1_b2b_flags", {28'd0, flags1}, 32'h1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
